// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: in-order requests to a variable-latency imem, a prefetch
// FIFO of {pc, inst}, and a valid/ready decode port with flush-on-redirect.
module riscv_fetch_unit #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       x_reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [XLEN-1:0]            dec_pc,
  output logic [XLEN-1:0]            dec_pc_plus4,
  output logic [XLEN-1:0]            dec_inst,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   inflight, discard, inflight_nxt;
  logic [XLEN-1:0] fetch_pc, rsp_pc, tgt_pc;
  logic [CW:0]     occ;
  logic            req_fire, rsp_ok, enq, deq;
  logic            unused_rpc_lo;

  assign tgt_pc        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // Live (non-discarded) in-flight requests each hold a reserved FIFO slot.
  assign occ = (CW+1)'(inflight) - (CW+1)'(discard) + (CW+1)'(count);

  assign imem_req_valid = !x_reset && !redirect_valid &&
                          (inflight < OW'(MAX_OUTSTANDING)) && (occ < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol violation and is ignored.
  assign rsp_ok       = imem_rsp_valid && (inflight != '0);
  assign enq          = rsp_ok && (discard == '0) && !redirect_valid;
  assign inflight_nxt = inflight + OW'(req_fire) - OW'(rsp_ok);

  assign dec_valid    = !x_reset && !redirect_valid && (count != '0);
  assign deq          = dec_valid && dec_ready;
  assign dec_pc       = fifo_q[rd_ptr].pc;
  assign dec_inst     = fifo_q[rd_ptr].inst;
  assign dec_pc_plus4 = dec_pc + XLEN'(4);
  assign fifo_count   = count;

  always_ff @(posedge clk) begin
    if (x_reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= tgt_pc;
        rsp_pc   <= tgt_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_ok && (discard != '0)) discard <= discard - OW'(1);
        if (enq) begin
          fifo_q[wr_ptr] <= '{pc: rsp_pc, inst: imem_rsp_data};
          wr_ptr         <= wr_ptr + PW'(1);
          rsp_pc         <= rsp_pc + XLEN'(4);
        end
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
endmodule
